// File: rtl/rd_data_collector.sv
// Read-data collector: pairs PHY read beats with queued read tags and routes bursts to host or periodic-read outputs.
// Optional beat pattern checker enabled by defining RDC_PATTERN_CHECK_EN.
module rd_data_collector #(
  parameter int DQ_WIDTH     = 64,
  parameter int BEATS_PER_RD = 2,
  parameter int TAG_DEPTH    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         dfi_rddata_en,
  input  logic                         dfi_rddata_en_odd,
  input  logic                         dfi_rddata_valid,
  input  logic [4*DQ_WIDTH-1:0]        dfi_rddata,
  output logic [4*DQ_WIDTH-1:0]        host_data,
  output logic                         host_valid,
  output logic                         host_last,
  output logic [4*DQ_WIDTH-1:0]        pr_data,
  output logic                         pr_valid,
  output logic                         pr_last,
  output logic [$clog2(TAG_DEPTH):0]   outstanding,
  output logic                         err_overflow,
  output logic                         err_orphan,
  input  logic [7:0]                   exp_pattern,
  output logic [15:0]                  mismatch_cnt
);

  localparam int DW = 4 * DQ_WIDTH;
  localparam int AW = $clog2(TAG_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [2:0]    LAST_BEAT = 3'(BEATS_PER_RD - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(TAG_DEPTH);

  logic          tag_mem [TAG_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [2:0]    beat_cnt;

  logic fifo_empty;
  logic fifo_full;
  logic head_tag;
  logic beat_ok;
  logic last_beat;
  logic pop;
  logic push_ok;
  logic overflow;
  logic orphan;

  // A push into a full FIFO is still legal when the last beat frees the head slot this cycle.
  always_comb begin
    fifo_empty = (outstanding == {CW{1'b0}});
    fifo_full  = (outstanding == FULL_CNT);
    head_tag   = tag_mem[rd_ptr];
    beat_ok    = dfi_rddata_valid && !fifo_empty;
    orphan     = dfi_rddata_valid && fifo_empty;
    last_beat  = beat_ok && (beat_cnt == LAST_BEAT);
    pop        = last_beat;
    push_ok    = dfi_rddata_en && (!fifo_full || pop);
    overflow   = dfi_rddata_en && fifo_full && !pop;
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      tag_mem[wr_ptr] <= dfi_rddata_en_odd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= {AW{1'b0}};
      rd_ptr       <= {AW{1'b0}};
      outstanding  <= {CW{1'b0}};
      beat_cnt     <= 3'd0;
      err_overflow <= 1'b0;
      err_orphan   <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
      if (last_beat) begin
        beat_cnt <= 3'd0;
      end else if (beat_ok) begin
        beat_cnt <= beat_cnt + 3'd1;
      end
      if (overflow) begin
        err_overflow <= 1'b1;
      end
      if (orphan) begin
        err_orphan <= 1'b1;
      end
    end
  end

  // Data registers hold their last value between beats; only the valid/last strobes pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      host_data  <= {DW{1'b0}};
      host_valid <= 1'b0;
      host_last  <= 1'b0;
      pr_data    <= {DW{1'b0}};
      pr_valid   <= 1'b0;
      pr_last    <= 1'b0;
    end else begin
      host_valid <= beat_ok && !head_tag;
      host_last  <= last_beat && !head_tag;
      pr_valid   <= beat_ok && head_tag;
      pr_last    <= last_beat && head_tag;
      if (beat_ok && !head_tag) begin
        host_data <= dfi_rddata;
      end
      if (beat_ok && head_tag) begin
        pr_data <= dfi_rddata;
      end
    end
  end

`ifdef RDC_PATTERN_CHECK_EN
  logic [DW-1:0] pattern_word;
  logic          beat_mismatch;

  always_comb begin
    pattern_word  = {(DW/8){exp_pattern}};
    beat_mismatch = beat_ok && (dfi_rddata != pattern_word);
  end

  // Saturating count of routed beats that differ from the replicated pattern byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch_cnt <= 16'h0000;
    end else if (beat_mismatch && (mismatch_cnt != 16'hFFFF)) begin
      mismatch_cnt <= mismatch_cnt + 16'h0001;
    end
  end
`else
  logic unused_pattern;
  assign unused_pattern = ^exp_pattern;
  assign mismatch_cnt   = 16'h0000;
`endif

endmodule

// File: tb/tb_rd_data_collector.sv
// Directed self-checking bench for rd_data_collector (default parameters).
module tb_rd_data_collector;

  localparam int DW = 256;

  logic          clk;
  logic          rst;
  logic          dfi_rddata_en;
  logic          dfi_rddata_en_odd;
  logic          dfi_rddata_valid;
  logic [DW-1:0] dfi_rddata;
  logic [DW-1:0] host_data;
  logic          host_valid;
  logic          host_last;
  logic [DW-1:0] pr_data;
  logic          pr_valid;
  logic          pr_last;
  logic [4:0]    outstanding;
  logic          err_overflow;
  logic          err_orphan;
  logic [7:0]    exp_pattern;
  logic [15:0]   mismatch_cnt;

  int checks = 0;
  int errors = 0;

  rd_data_collector dut (
    .clk(clk), .rst(rst),
    .dfi_rddata_en(dfi_rddata_en), .dfi_rddata_en_odd(dfi_rddata_en_odd),
    .dfi_rddata_valid(dfi_rddata_valid), .dfi_rddata(dfi_rddata),
    .host_data(host_data), .host_valid(host_valid), .host_last(host_last),
    .pr_data(pr_data), .pr_valid(pr_valid), .pr_last(pr_last),
    .outstanding(outstanding), .err_overflow(err_overflow), .err_orphan(err_orphan),
    .exp_pattern(exp_pattern), .mismatch_cnt(mismatch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then return 1 time unit after the edge with inputs idle.
  task automatic cyc(input logic en, input logic odd, input logic v, input logic [DW-1:0] d);
    dfi_rddata_en     = en;
    dfi_rddata_en_odd = odd;
    dfi_rddata_valid  = v;
    dfi_rddata        = d;
    @(posedge clk);
    #1;
    dfi_rddata_en     = 1'b0;
    dfi_rddata_en_odd = 1'b0;
    dfi_rddata_valid  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, '0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (host_valid !== 1'b0 || host_last !== 1'b0 || host_data !== '0) begin errors++; $display("FAIL reset_host: got v=%b l=%b d=%h, expected 0", host_valid, host_last, host_data); end
    checks++; if (pr_valid !== 1'b0 || pr_last !== 1'b0 || pr_data !== '0) begin errors++; $display("FAIL reset_pr: got v=%b l=%b d=%h, expected 0", pr_valid, pr_last, pr_data); end
    checks++; if (outstanding !== 5'd0 || err_overflow !== 1'b0 || err_orphan !== 1'b0 || mismatch_cnt !== 16'h0000) begin errors++; $display("FAIL reset_status: got out=%0d ovf=%b orph=%b mm=%0d, expected 0", outstanding, err_overflow, err_orphan, mismatch_cnt); end
  endtask

  task automatic test_single_read();
    logic [DW-1:0] aa;
    logic [DW-1:0] x55;
    aa  = {32{8'hAA}};
    x55 = {32{8'h55}};
    cyc(1'b1, 1'b0, 1'b0, '0);
    checks++; if (outstanding !== 5'd1) begin errors++; $display("FAIL single_push: outstanding got %0d expected 1", outstanding); end
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b1, aa);
    checks++; if (host_valid !== 1'b1 || host_last !== 1'b0 || host_data !== aa || pr_valid !== 1'b0) begin errors++; $display("FAIL single_beat0: got hv=%b hl=%b pv=%b d=%h", host_valid, host_last, pr_valid, host_data); end
    checks++; if (outstanding !== 5'd1) begin errors++; $display("FAIL single_out_mid: got %0d expected 1", outstanding); end
    cyc(1'b0, 1'b0, 1'b1, x55);
    checks++; if (host_valid !== 1'b1 || host_last !== 1'b1 || host_data !== x55 || pr_valid !== 1'b0) begin errors++; $display("FAIL single_beat1: got hv=%b hl=%b pv=%b d=%h", host_valid, host_last, pr_valid, host_data); end
    checks++; if (outstanding !== 5'd0) begin errors++; $display("FAIL single_out_end: got %0d expected 0", outstanding); end
    cyc(1'b0, 1'b0, 1'b0, '0);
    checks++; if (host_valid !== 1'b0 || host_last !== 1'b0 || host_data !== x55) begin errors++; $display("FAIL single_hold: got hv=%b hl=%b d=%h, expected 0 0 55..", host_valid, host_last, host_data); end
  endtask

  task automatic test_interleave();
    logic [5:0] exp_host;
    logic [DW-1:0] d;
    exp_host = 6'b110011;
    cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b0, '0);
    checks++; if (outstanding !== 5'd3) begin errors++; $display("FAIL inter_push: outstanding got %0d expected 3", outstanding); end
    for (int i = 0; i < 6; i++) begin
      d = DW'(i + 16);
      cyc(1'b0, 1'b0, 1'b1, d);
      checks++;
      if (host_valid !== exp_host[i] || pr_valid !== !exp_host[i] ||
          host_last !== (exp_host[i] && i[0]) || pr_last !== (!exp_host[i] && i[0]) ||
          (exp_host[i] ? host_data : pr_data) !== d) begin
        errors++;
        $display("FAIL inter_beat%0d: got hv=%b hl=%b pv=%b pl=%b, expected host=%b last=%b", i, host_valid, host_last, pr_valid, pr_last, exp_host[i], i[0]);
      end
    end
    checks++; if (outstanding !== 5'd0) begin errors++; $display("FAIL inter_end: outstanding got %0d expected 0", outstanding); end
  endtask

  task automatic test_overflow();
    int nvalid;
    int nlast;
    for (int i = 0; i < 17; i++) cyc(1'b1, 1'b0, 1'b0, '0);
    checks++; if (outstanding !== 5'd16 || err_overflow !== 1'b1) begin errors++; $display("FAIL ovf_fill: got out=%0d ovf=%b expected 16 1", outstanding, err_overflow); end
    nvalid = 0;
    nlast  = 0;
    for (int i = 0; i < 32; i++) begin
      cyc(1'b0, 1'b0, 1'b1, DW'(i));
      if (host_valid === 1'b1) nvalid++;
      if (host_last === 1'b1) nlast++;
    end
    checks++; if (nvalid != 32 || nlast != 16) begin errors++; $display("FAIL ovf_drain: got beats=%0d lasts=%0d expected 32 16", nvalid, nlast); end
    checks++; if (outstanding !== 5'd0 || err_orphan !== 1'b0) begin errors++; $display("FAIL ovf_end: got out=%0d orph=%b expected 0 0", outstanding, err_orphan); end
  endtask

  task automatic test_orphan_simul();
    do_reset();
    cyc(1'b0, 1'b0, 1'b1, {32{8'h11}});
    checks++; if (host_valid !== 1'b0 || pr_valid !== 1'b0 || err_orphan !== 1'b1 || host_data !== '0) begin errors++; $display("FAIL orphan: got hv=%b pv=%b orph=%b", host_valid, pr_valid, err_orphan); end
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b0, '0);
    checks++; if (outstanding !== 5'd16 || err_overflow !== 1'b0) begin errors++; $display("FAIL simul_fill: got out=%0d ovf=%b expected 16 0", outstanding, err_overflow); end
    cyc(1'b0, 1'b0, 1'b1, DW'(1));
    checks++; if (host_valid !== 1'b1 || host_last !== 1'b0) begin errors++; $display("FAIL orphan_cnt: first beat after orphan got hv=%b hl=%b expected 1 0", host_valid, host_last); end
    cyc(1'b1, 1'b0, 1'b1, DW'(2));
    checks++; if (host_last !== 1'b1 || outstanding !== 5'd16 || err_overflow !== 1'b0) begin errors++; $display("FAIL simul_full: got hl=%b out=%0d ovf=%b expected 1 16 0", host_last, outstanding, err_overflow); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b1, {32{8'h3C}});
    checks++; if (host_valid !== 1'b1 || host_last !== 1'b0) begin errors++; $display("FAIL mid_beat0: got hv=%b hl=%b expected 1 0", host_valid, host_last); end
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, {32{8'h3C}});
    rst = 1'b0;
    checks++; if (host_valid !== 1'b0 || host_data !== '0 || outstanding !== 5'd0 || pr_valid !== 1'b0) begin errors++; $display("FAIL mid_reset: got hv=%b out=%0d d=%h expected 0 0 0", host_valid, outstanding, host_data); end
    cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b1, DW'(7));
    checks++; if (host_valid !== 1'b1 || host_last !== 1'b0) begin errors++; $display("FAIL mid_new0: got hv=%b hl=%b expected 1 0", host_valid, host_last); end
    cyc(1'b0, 1'b0, 1'b1, DW'(8));
    checks++; if (host_valid !== 1'b1 || host_last !== 1'b1 || host_data !== DW'(8) || outstanding !== 5'd0) begin errors++; $display("FAIL mid_new1: got hv=%b hl=%b out=%0d expected 1 1 0", host_valid, host_last, outstanding); end
  endtask

  task automatic test_pattern();
    logic [DW-1:0] good;
    logic [DW-1:0] bad;
    logic [15:0]   exp_cnt;
    good = {32{8'hA5}};
    bad  = good;
    bad[7:0] = 8'h5A;
`ifdef RDC_PATTERN_CHECK_EN
    exp_cnt = 16'd1;
`else
    exp_cnt = 16'd0;
`endif
    do_reset();
    exp_pattern = 8'hA5;
    cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b1, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b1, good);
    cyc(1'b0, 1'b0, 1'b1, good);
    checks++; if (mismatch_cnt !== 16'd0) begin errors++; $display("FAIL pat_good: mismatch_cnt got %0d expected 0", mismatch_cnt); end
    cyc(1'b0, 1'b0, 1'b1, bad);
    checks++; if (mismatch_cnt !== exp_cnt || pr_valid !== 1'b1) begin errors++; $display("FAIL pat_bad: mismatch_cnt got %0d expected %0d (pv=%b)", mismatch_cnt, exp_cnt, pr_valid); end
    cyc(1'b0, 1'b0, 1'b1, good);
    checks++; if (mismatch_cnt !== exp_cnt || pr_last !== 1'b1) begin errors++; $display("FAIL pat_end: mismatch_cnt got %0d expected %0d (pl=%b)", mismatch_cnt, exp_cnt, pr_last); end
  endtask

  initial begin
    rst = 1'b1;
    dfi_rddata_en = 1'b0;
    dfi_rddata_en_odd = 1'b0;
    dfi_rddata_valid = 1'b0;
    dfi_rddata = '0;
    exp_pattern = 8'h00;
    test_reset();
    test_single_read();
    test_interleave();
    test_overflow();
    test_orphan_simul();
    test_reset_mid_burst();
    test_pattern();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
